// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data memory arbiter with a fixed 4-cycle transaction and fetch anti-starvation
module mem_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    input  logic          halt,
    output logic          if_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic          own_f_q, own_f_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_done_q, if_done_d;
    logic          d_done_q, d_done_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic f_elig, grant_d, grant_f;

    // Data has priority except when fetch has lost STARVE_LIMIT times in a row.
    assign f_elig  = if_req & ~halt;
    assign grant_d = d_req & ~(f_elig & (starve_q == LIMIT));
    assign grant_f = f_elig & ~grant_d;

    always_comb begin
        state_d     = state_q;
        own_f_d     = own_f_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        starve_d    = starve_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    own_f_d = 1'b0;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    state_d = ISSUE;
                end else if (grant_f) begin
                    own_f_d = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    state_d = ISSUE;
                end
                if (!if_req || grant_f) begin
                    starve_d = '0;
                end else if (f_elig && grant_d && starve_q != LIMIT) begin
                    starve_d = starve_q + SW'(1);
                end
            end
            ISSUE: begin
                mem_en_d    = 1'b1;
                mem_we_d    = we_q;
                mem_addr_d  = addr_q;
                mem_wdata_d = wdata_q;
                state_d     = WAIT;
            end
            WAIT: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                if (own_f_q) begin
                    if_done_d  = 1'b1;
                    if_rdata_d = mem_rdata;
                end else begin
                    d_done_d  = 1'b1;
                    d_rdata_d = we_q ? '0 : mem_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            own_f_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            own_f_q     <= own_f_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_stall  = if_req & ~if_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level reference model
module tb_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, halt = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          if_done, d_done, if_stall, mem_en, mem_we;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .halt(halt), .if_stall(if_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int miss = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous-read memory attached to the DUT.
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Reference model: a granted transaction occupies four cycles counted from the grant edge.
    logic [DW-1:0] ref_mem [1024];
    bit            m_busy, m_f, m_we;
    int            m_age, m_starve;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          e_if_done, e_d_done, e_mem_en, e_mem_we;
    logic [DW-1:0] e_if_rdata, e_d_rdata, e_mem_wdata;
    logic [AW-1:0] e_mem_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_age = 0; m_starve = 0;
            e_if_done = 0; e_d_done = 0; e_mem_en = 0; e_mem_we = 0;
            e_if_rdata = 0; e_d_rdata = 0; e_mem_wdata = 0; e_mem_addr = 0;
        end else begin
            e_if_done = 0;
            e_d_done  = 0;
            if (m_busy) begin
                m_age++;
                if (m_age == 1) begin
                    e_mem_en = 1; e_mem_we = m_we; e_mem_addr = m_addr; e_mem_wdata = m_wdata;
                end else if (m_age == 2) begin
                    e_mem_en = 0; e_mem_we = 0;
                end else begin
                    if (m_f) begin
                        e_if_done = 1; e_if_rdata = ref_mem[m_addr];
                    end else begin
                        e_d_done = 1;
                        e_d_rdata = m_we ? '0 : ref_mem[m_addr];
                        if (m_we) ref_mem[m_addr] = m_wdata;
                    end
                    m_busy = 0;
                end
            end else begin
                bit fe, take_f, take_d;
                fe     = if_req && !halt;
                take_f = fe && (!d_req || m_starve == LIM);
                take_d = d_req && !take_f;
                if (!if_req || take_f) m_starve = 0;
                else if (fe && take_d) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
                if (take_f || take_d) begin
                    m_busy = 1; m_age = 0; m_f = take_f;
                    m_we    = take_d ? d_we : 1'b0;
                    m_addr  = take_d ? d_addr : if_addr;
                    m_wdata = take_d ? d_wdata : '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        check("if_done", if_done, e_if_done);
        check("d_done", d_done, e_d_done);
        check("if_rdata", if_rdata, e_if_rdata);
        check("d_rdata", d_rdata, e_d_rdata);
        check("mem_en", mem_en, e_mem_en);
        check("mem_we", mem_we, e_mem_we);
        check("mem_addr", mem_addr, e_mem_addr);
        if (e_mem_we) check("mem_wdata", mem_wdata, e_mem_wdata);
        check("if_stall", if_stall, if_req & ~e_if_done);
    end

    typedef struct {
        bit            f;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } row_t;

    row_t rows[$];

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns the number of negedges until the wanted done pulse, 0 on timeout.
    task automatic wait_done(input bit want_f, output int k);
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            #2;
            if (want_f ? if_done : d_done) begin
                k = i;
                break;
            end
        end
        if (k == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int k, cnt, n_done;
        bit f_act, d_act;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        mem[0] = 32'h2801_0078;
        ref_mem[0] = 32'h2801_0078;

        rows.push_back('{0, 1, 10'd121, 32'd85, 32'd0});
        rows.push_back('{0, 0, 10'd121, 32'd0, 32'd85});
        rows.push_back('{1, 0, 10'd0, 32'd0, 32'h2801_0078});
        rows.push_back('{0, 1, 10'd5, 32'hDEAD_BEEF, 32'd0});
        rows.push_back('{1, 0, 10'd5, 32'd0, 32'hDEAD_BEEF});
        rows.push_back('{0, 0, 10'd0, 32'd0, 32'h2801_0078});

        repeat (3) @(negedge clk);
        #2;
        check("rst_mem_en", mem_en, 0);
        check("rst_d_rdata", d_rdata, 0);
        rst_n = 1'b1;

        // Directed single transactions with fixed latency.
        foreach (rows[r]) begin
            if (rows[r].f) begin
                if_req = 1; if_addr = rows[r].addr;
            end else begin
                d_req = 1; d_we = rows[r].we; d_addr = rows[r].addr; d_wdata = rows[r].wdata;
            end
            wait_done(rows[r].f, k);
            check($sformatf("row%0d_latency", r), k, 4);
            check($sformatf("row%0d_rdata", r), rows[r].f ? if_rdata : d_rdata, rows[r].exp);
            check($sformatf("row%0d_other_done", r), rows[r].f ? d_done : if_done, 0);
            if_req = 0; d_req = 0;
            idle(2);
        end

        // Both held: D,D,D,D,F repeating.
        if_req = 1; if_addr = 0; d_req = 1; d_we = 0; d_addr = 121;
        n_done = 0;
        for (int c = 0; c < 80 && n_done < 15; c++) begin
            @(negedge clk);
            #2;
            if (if_done || d_done) begin
                check("both_done_once", {31'd0, if_done & d_done}, 0);
                check($sformatf("grant%0d_is_fetch", n_done), if_done, (n_done % 5 == 4));
                n_done++;
            end
        end
        check("grant_count", n_done, 15);
        if_req = 0; d_req = 0;
        idle(5);

        // Halt blocks fetch; data still served; fetch follows once halt drops.
        halt = 1; if_req = 1; if_addr = 0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            #2;
            if (mem_en) cnt++;
        end
        check("halt_no_mem_en", cnt, 0);
        d_req = 1; d_we = 0; d_addr = 121;
        wait_done(0, k);
        check("halt_data_latency", k, 4);
        check("halt_data_rdata", d_rdata, 85);
        d_req = 0; halt = 0;
        wait_done(1, k);
        check("halt_fetch_served", k, 4);
        if_req = 0;
        idle(3);

        // Reset while a store is in WAIT.
        d_req = 1; d_we = 1; d_addr = 200; d_wdata = 7;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("rstw_mem_en", mem_en, 0);
        check("rstw_mem_addr", mem_addr, 0);
        check("rstw_mem_wdata", mem_wdata, 0);
        check("rstw_d_done", d_done, 0);
        check("rstw_if_rdata", if_rdata, 0);
        @(negedge clk);
        rst_n = 1;
        wait_done(0, k);
        check("rstw_reissue_latency", k, 4);
        check("rstw_store_rdata", d_rdata, 0);
        d_req = 0;
        idle(2);

        // Data request dropped right after grant.
        d_req = 1; d_we = 0; d_addr = 200;
        @(posedge clk);
        @(negedge clk);
        d_req = 0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            #2;
            if (d_done) cnt++;
        end
        check("drop_done_once", cnt, 1);
        check("drop_rdata", d_rdata, 7);

        // Random protocol-respecting traffic against the model.
        f_act = 0; d_act = 0;
        repeat (600) begin
            @(negedge clk);
            #2;
            if (f_act && if_done) f_act = 0;
            if (d_act && d_done) d_act = 0;
            if (!f_act) begin
                if ($urandom_range(2) == 0) begin
                    f_act = 1; if_req = 1; if_addr = AW'($urandom_range(15));
                end else if_req = 0;
            end
            if (!d_act) begin
                if ($urandom_range(2) == 0) begin
                    d_act = 1; d_req = 1; d_we = 1'($urandom_range(1));
                    d_addr = AW'($urandom_range(15)); d_wdata = $urandom;
                end else d_req = 0;
            end
            if ($urandom_range(7) == 0) halt = ~halt;
        end
        halt = 0; if_req = 0; d_req = 0;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
